// File: rtl/imm_decode_pkg.sv
// Shared types for the decode buffer: format codes, opcode constants and the queued entry.
// Optional U/J decoding is enabled by defining IMM_UJ_EN.
package imm_decode_pkg;

    localparam int unsigned IMM_W = 64;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        fmt_e             fmt;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic             illegal;
    } entry_t;

endpackage

// File: rtl/imm_decode_fifo.sv
// DEPTH-entry synchronous FIFO of decoded entries; pointers wrap naturally (DEPTH is 2^n).
module imm_decode_fifo
    import imm_decode_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Empty FIFO presents an all-zero entry so out_* data reads 0 when idle.
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/imm_decode_buffer.sv
// Decode front end: classifies instructions, extracts fields/immediate, queues for execute.
// Define IMM_UJ_EN to decode U-type (lui/auipc) and J-type (jal) instead of flagging them.
module imm_decode_buffer
    import imm_decode_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    entry_t           dec;
    entry_t           head;
    logic             full;
    logic             empty;
    logic             accept;
    logic [CNT_W-1:0] illegal_count_q;

    always_comb begin
        dec         = '0;
        dec.rd      = in_instr[11:7];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b1;
        case (in_instr[6:0])
            OPC_OP: begin
                dec.fmt     = FMT_R;
                dec.illegal = 1'b0;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                dec.fmt     = FMT_I;
                dec.illegal = 1'b0;
                dec.imm     = {{(IMM_W-12){in_instr[31]}}, in_instr[31:20]};
            end
            OPC_STORE: begin
                dec.fmt     = FMT_S;
                dec.illegal = 1'b0;
                dec.imm     = {{(IMM_W-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_BRANCH: begin
                dec.fmt     = FMT_B;
                dec.illegal = 1'b0;
                dec.imm     = {{(IMM_W-13){in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
            end
`ifdef IMM_UJ_EN
            OPC_LUI, OPC_AUIPC: begin
                dec.fmt     = FMT_U;
                dec.illegal = 1'b0;
                dec.imm     = {{(IMM_W-32){in_instr[31]}}, in_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec.fmt     = FMT_J;
                dec.illegal = 1'b0;
                dec.imm     = {{(IMM_W-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
            end
`endif
            default: begin
                dec.fmt     = FMT_NONE;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // in_ready depends only on registered FIFO occupancy.
    assign in_ready = !full;
    assign accept   = in_valid && in_ready && !flush;

    imm_decode_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (accept),
        .wdata (dec),
        .pop   (out_valid && out_ready),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_count_q <= '0;
        end else if (accept && dec.illegal && (illegal_count_q != '1)) begin
            illegal_count_q <= illegal_count_q + 1'b1;
        end
    end

    assign out_valid     = !empty;
    assign out_imm       = head.imm[XLEN-1:0];
    assign out_fmt       = head.fmt;
    assign out_rd        = head.rd;
    assign out_rs1       = head.rs1;
    assign out_rs2       = head.rs2;
    assign out_illegal   = head.illegal;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_imm_decode_buffer.sv
// Directed bench for imm_decode_buffer; a second instance with a 2-bit counter checks saturation.
module tb_imm_decode_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_illegal;
    logic [15:0] illegal_count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [63:0] s_out_imm;
    logic [2:0]  s_out_fmt;
    logic [4:0]  s_out_rd;
    logic [4:0]  s_out_rs1;
    logic [4:0]  s_out_rs2;
    logic        s_out_illegal;
    logic [1:0]  s_illegal_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imm_decode_buffer u_dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_imm       (out_imm),
        .out_fmt       (out_fmt),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_illegal   (out_illegal),
        .illegal_count (illegal_count)
    );

    imm_decode_buffer #(
        .CNT_W (2)
    ) u_sat (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (s_in_ready),
        .in_instr      (in_instr),
        .out_valid     (s_out_valid),
        .out_ready     (out_ready),
        .out_imm       (s_out_imm),
        .out_fmt       (s_out_fmt),
        .out_rd        (s_out_rd),
        .out_rs1       (s_out_rs1),
        .out_rs2       (s_out_rs2),
        .out_illegal   (s_out_illegal),
        .illegal_count (s_illegal_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_illegal_count", illegal_count, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_out_fmt", out_fmt, 0);
        check("rst_out_rd", out_rd, 0);
        rst = 1'b0;

        // addi x1,x0,-1
        send(32'hFFF00093);
        check("addi_valid", out_valid, 1);
        check("addi_fmt", out_fmt, 3'd1);
        check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_rd", out_rd, 5'd1);
        check("addi_illegal", out_illegal, 0);

        // sd x2,8(x1)
        send(32'h0020B423);
        check("sd_fmt", out_fmt, 3'd2);
        check("sd_imm", out_imm, 64'd8);
        check("sd_rs1", out_rs1, 5'd1);
        check("sd_rs2", out_rs2, 5'd2);
        check("sd_rd_field", out_rd, 5'd8);

        // beq x0,x0,-4
        send(32'hFE000EE3);
        check("beq_fmt", out_fmt, 3'd3);
        check("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_imm_zero", out_imm, 0);

        // Back-pressure: three offers with the consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        tick();
        check("bp_ready_after1", in_ready, 1);
        in_instr = 32'h00200113;
        tick();
        check("bp_ready_full", in_ready, 0);
        check("bp_head_a", out_imm, 64'd1);
        in_instr = 32'h00300193;
        tick();
        check("bp_still_full", in_ready, 0);
        check("bp_head_hold", out_imm, 64'd1);
        out_ready = 1'b1;
        tick();
        check("bp_head_b", out_imm, 64'd2);
        check("bp_ready_freed", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_head_c_imm", out_imm, 64'd3);
        check("bp_head_c_rd", out_rd, 5'd3);
        tick();
        check("bp_empty", out_valid, 0);

        // count=1 then simultaneous push+pop
        out_ready = 1'b0;
        send(32'h00400213);
        check("pp_pre_head", out_imm, 64'd4);
        out_ready = 1'b1;
        send(32'h00500293);
        check("pp_valid", out_valid, 1);
        check("pp_head_e", out_imm, 64'd5);
        check("pp_ready", in_ready, 1);

        // Flush with an illegal instruction offered: dropped and not counted
        out_ready = 1'b0;
        flush     = 1'b1;
        send(32'h0000007F);
        flush = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_ready", in_ready, 1);
        check("flush_not_counted", illegal_count, 0);
        out_ready = 1'b1;
        tick();
        check("flush_stays_empty", out_valid, 0);

        // Illegal opcodes and counter saturation
        send(32'h0000007F);
        check("ill1_flag", out_illegal, 1);
        check("ill1_imm", out_imm, 0);
        check("ill1_fmt", out_fmt, 3'd7);
        send(32'h0000007F);
        check("ill2_flag", out_illegal, 1);
        send(32'h0000007F);
        check("ill3_flag", out_illegal, 1);
        check("ill3_count", illegal_count, 16'd3);
        check("ill3_sat_count", s_illegal_count, 2'd3);
        send(32'h0000007F);
        check("ill4_count", illegal_count, 16'd4);
        check("ill4_sat_hold", s_illegal_count, 2'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_count", illegal_count, 0);
        check("rst2_sat_count", s_illegal_count, 0);
        check("rst2_valid", out_valid, 0);

        // lui x5,0x12345
        send(32'h123452B7);
        check("lui_rd", out_rd, 5'd5);
`ifdef IMM_UJ_EN
        check("lui_fmt", out_fmt, 3'd4);
        check("lui_imm", out_imm, 64'h0000_0000_1234_5000);
        check("lui_illegal", out_illegal, 0);
        check("lui_count", illegal_count, 0);
`else
        check("lui_fmt", out_fmt, 3'd7);
        check("lui_imm", out_imm, 0);
        check("lui_illegal", out_illegal, 1);
        check("lui_count", illegal_count, 16'd1);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
